// File: rtl/mem_port_arbiter_if.sv
// Requester-side and downstream-side bus bundle for mem_port_arbiter.
// Per-port request fields are packed, so port i sits at [i*W +: W].
interface mem_port_arbiter_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int BE_W      = DATA_W / 8
);
  logic [NUM_PORTS-1:0]        req_read;
  logic [NUM_PORTS-1:0]        req_write;
  logic [NUM_PORTS*ADDR_W-1:0] req_address;
  logic [NUM_PORTS*DATA_W-1:0] req_wdata;
  logic [NUM_PORTS*BE_W-1:0]   req_byte_enable;
  logic [DATA_W-1:0]           req_rdata;
  logic [NUM_PORTS-1:0]        req_resp;

  logic [ADDR_W-1:0]           mem_address;
  logic [DATA_W-1:0]           mem_wdata;
  logic [BE_W-1:0]             mem_byte_enable;
  logic                        mem_read;
  logic                        mem_write;
  logic [DATA_W-1:0]           mem_rdata;
  logic                        mem_resp;

  modport slave (
    input  req_read,
    input  req_write,
    input  req_address,
    input  req_wdata,
    input  req_byte_enable,
    output req_rdata,
    output req_resp,
    output mem_address,
    output mem_wdata,
    output mem_byte_enable,
    output mem_read,
    output mem_write,
    input  mem_rdata,
    input  mem_resp
  );

  modport master (
    output req_read,
    output req_write,
    output req_address,
    output req_wdata,
    output req_byte_enable,
    input  req_rdata,
    input  req_resp,
    input  mem_address,
    input  mem_wdata,
    input  mem_byte_enable,
    input  mem_read,
    input  mem_write,
    output mem_rdata,
    output mem_resp
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// N-port memory arbiter: fixed-priority or round-robin, one access in
// flight, downstream command held from latched registers until mem_resp.
module mem_port_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int ARB_MODE  = 0,
  parameter int BE_W      = DATA_W / 8,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic             clk,
  input  logic             reset,
  mem_port_arbiter_if.slave bus,
  output logic             busy,
  output logic [IDX_W-1:0] grant_idx
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
    logic              write;
    logic [IDX_W-1:0]  idx;
  } cmd_t;

  state_t           state_q;
  state_t           state_d;
  cmd_t             cmd_q;
  cmd_t             cmd_d;
  logic [IDX_W-1:0] rr_q;
  logic [IDX_W-1:0] rr_d;

  logic [NUM_PORTS-1:0] pending;
  logic                 any_pending;
  logic [IDX_W-1:0]     win_fixed;
  logic [IDX_W-1:0]     win_rr;
  logic [IDX_W-1:0]     win;
  logic [IDX_W:0]       rr_sum;
  logic                 done;

  assign pending     = bus.req_read | bus.req_write;
  assign any_pending = |pending;

  always_comb begin : fixed_pick
    win_fixed = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (pending[i]) win_fixed = IDX_W'(i);
    end
  end

  // Scan downward so the last hit is the first pending port at/after rr_q.
  always_comb begin : rr_pick
    win_rr = rr_q;
    rr_sum = '0;
    for (int off = NUM_PORTS - 1; off >= 0; off--) begin
      rr_sum = {1'b0, rr_q} + (IDX_W+1)'(off);
      if (rr_sum >= (IDX_W+1)'(NUM_PORTS))
        rr_sum = rr_sum - (IDX_W+1)'(NUM_PORTS);
      if (pending[rr_sum[IDX_W-1:0]])
        win_rr = rr_sum[IDX_W-1:0];
    end
  end

  assign win = (ARB_MODE == 1) ? win_rr : win_fixed;

  always_comb begin : next_state
    state_d = state_q;
    cmd_d   = cmd_q;
    rr_d    = rr_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_pending) begin
          state_d     = BUSY;
          cmd_d.addr  = bus.req_address[win*ADDR_W +: ADDR_W];
          cmd_d.wdata = bus.req_wdata[win*DATA_W +: DATA_W];
          cmd_d.be    = bus.req_byte_enable[win*BE_W +: BE_W];
          cmd_d.write = bus.req_write[win];
          cmd_d.idx   = win;
        end
      end
      BUSY: begin
        if (bus.mem_resp) begin
          state_d = IDLE;
          done    = 1'b1;
          if (cmd_q.idx == IDX_W'(NUM_PORTS - 1))
            rr_d = '0;
          else
            rr_d = cmd_q.idx + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      rr_q    <= rr_d;
    end
  end

  assign busy      = (state_q == BUSY);
  assign grant_idx = cmd_q.idx;

  assign bus.mem_read        = busy & ~cmd_q.write;
  assign bus.mem_write       = busy & cmd_q.write;
  assign bus.mem_address     = cmd_q.addr;
  assign bus.mem_wdata       = cmd_q.wdata;
  assign bus.mem_byte_enable = cmd_q.be;
  assign bus.req_rdata       = bus.mem_rdata;

  always_comb begin : resp_decode
    bus.req_resp = '0;
    if (done) bus.req_resp[cmd_q.idx] = 1'b1;
  end

  a_resp_onehot : assert property (
    @(posedge clk) disable iff (reset) $onehot0(bus.req_resp));

  a_rw_excl : assert property (
    @(posedge clk) disable iff (reset) !(bus.mem_read && bus.mem_write));

endmodule
